// File: rtl/alu_shift_seq_ctrl.sv
// rtl/alu_shift_seq_ctrl.sv - iterative multi-cycle shifter with request/response handshakes
// Optional arithmetic right shift enabled by defining ALU_SHIFT_SEQ_ARITH_EN.

package simple_processor_pkg;
  localparam int unsigned DATA_WIDTH = 32;
endpackage

module alu_shift_seq_ctrl
  import simple_processor_pkg::*;
#(
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned STEP_LOG2   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_dir_i,
  input  logic                   req_arith_i,
  input  logic [DATA_WIDTH-1:0]  rs1_data_i,
  input  logic [SHIFT_WIDTH-1:0] amount_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  rsp_data_o,
  output logic                   busy_o
);

  localparam logic [SHIFT_WIDTH-1:0] STEP_AMT = SHIFT_WIDTH'(1 << STEP_LOG2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SHIFT_WIDTH-1:0] remaining;
  logic [SHIFT_WIDTH-1:0] step;
  logic                   dir_q;
  logic [DATA_WIDTH-1:0]  shifted;
  logic                   accept;

`ifdef ALU_SHIFT_SEQ_ARITH_EN
  logic                   arith_q;
  logic [DATA_WIDTH-1:0]  fill_mask;
`else
  logic                   unused_arith;
  assign unused_arith = req_arith_i;
`endif

  assign accept = req_valid_i & req_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (amount_i == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (remaining == step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (flush_i) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    req_ready_o = (state == IDLE) & ~flush_i & ~rst_i;
    rsp_valid_o = (state == DONE);
    busy_o      = (state == SHIFT) | (state == DONE);
  end

  // One iteration: shift by up to STEP bits; the sign bit is preserved across
  // iterations, so the current MSB is the latched operand MSB.
  always_comb begin
    step = (remaining < STEP_AMT) ? remaining : STEP_AMT;
    if (dir_q) begin
      shifted = rsp_data_o >> step;
`ifdef ALU_SHIFT_SEQ_ARITH_EN
      fill_mask = ~({DATA_WIDTH{1'b1}} >> step);
      if (arith_q && rsp_data_o[DATA_WIDTH-1]) begin
        shifted = shifted | fill_mask;
      end
`endif
    end else begin
      shifted = rsp_data_o << step;
`ifdef ALU_SHIFT_SEQ_ARITH_EN
      fill_mask = '0;
`endif
    end
  end

  // rsp_data_o doubles as the working register; flush leaves it untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_data_o <= '0;
      remaining  <= '0;
      dir_q      <= 1'b0;
`ifdef ALU_SHIFT_SEQ_ARITH_EN
      arith_q    <= 1'b0;
`endif
    end else if (accept) begin
      rsp_data_o <= rs1_data_i;
      remaining  <= amount_i;
      dir_q      <= req_dir_i;
`ifdef ALU_SHIFT_SEQ_ARITH_EN
      arith_q    <= req_arith_i & req_dir_i;
`endif
    end else if ((state == SHIFT) && !flush_i) begin
      rsp_data_o <= shifted;
      remaining  <= remaining - step;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq_ctrl.sv
// tb/tb_alu_shift_seq_ctrl.sv - directed vector bench for alu_shift_seq_ctrl
// Expected arithmetic results follow ALU_SHIFT_SEQ_ARITH_EN.

module tb_alu_shift_seq_ctrl;

`ifdef ALU_SHIFT_SEQ_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_dir = 1'b0;
  logic        req_arith = 1'b0;
  logic [31:0] rs1_data = '0;
  logic [4:0]  amount = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;

  int total = 0;
  int bad = 0;

  alu_shift_seq_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_dir_i   (req_dir),
    .req_arith_i (req_arith),
    .rs1_data_i  (rs1_data),
    .amount_i    (amount),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        dir;
    logic        arith;
    logic [4:0]  amt;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response, check latency/data, consume it.
  task automatic run_op(input logic [31:0] d, input logic dir, input logic arith,
                        input logic [4:0] amt, input logic [31:0] exp, input int lat,
                        input string tag);
    int n;
    rs1_data  = d;
    req_dir   = dir;
    req_arith = arith;
    amount    = amt;
    req_valid = 1'b1;
    #1;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " data"}, rsp_data, exp);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " idle_after_rsp"}, {30'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic        saw_valid;

    vecs[0]  = '{32'h0000_00F0, 1'b0, 1'b0, 5'd4,  32'h0000_0F00, 2};
    vecs[1]  = '{32'h8000_0000, 1'b1, 1'b0, 5'd31, 32'h0000_0001, 9};
    vecs[2]  = '{32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0,  32'hDEAD_BEEF, 1};
    vecs[3]  = '{32'h8000_0000, 1'b1, 1'b1, 5'd4,  ARITH ? 32'hF800_0000 : 32'h0800_0000, 2};
    vecs[4]  = '{32'h1234_5679, 1'b0, 1'b0, 5'd31, 32'h8000_0000, 9};
    vecs[5]  = '{32'hF000_0000, 1'b1, 1'b1, 5'd7,  ARITH ? 32'hFFE0_0000 : 32'h01E0_0000, 3};
    vecs[6]  = '{32'hA5A5_A5A5, 1'b0, 1'b1, 5'd8,  32'hA5A5_A500, 3};
    vecs[7]  = '{32'h7FFF_FFFF, 1'b1, 1'b1, 5'd1,  32'h3FFF_FFFF, 2};
    vecs[8]  = '{32'h0000_FFFF, 1'b0, 1'b0, 5'd16, 32'hFFFF_0000, 5};
    vecs[9]  = '{32'h8000_0000, 1'b1, 1'b1, 5'd31, ARITH ? 32'hFFFF_FFFF : 32'h0000_0001, 9};
    vecs[10] = '{32'h0000_0001, 1'b0, 1'b0, 5'd5,  32'h0000_0020, 3};

    // Reset state
    tick();
    tick();
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst req_ready", 32'(req_ready), 32'd1);
    tick();

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].data, vecs[i].dir, vecs[i].arith, vecs[i].amt,
             vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Flush beats a same-cycle accept in IDLE
    rs1_data = 32'h5555_5555; req_dir = 1'b0; amount = 5'd2;
    req_valid = 1'b1; flush = 1'b1;
    #1;
    check("flush_idle req_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle busy", 32'(busy), 32'd0);

    // Response back-pressure with a pending request
    run_op(32'h0000_0003, 1'b0, 1'b0, 5'd3, 32'h0000_0018, 2, "pre_hold");
    rs1_data = 32'h0000_0007; req_dir = 1'b0; req_arith = 1'b0; amount = 5'd3;
    req_valid = 1'b1;
    tick();
    tick();
    check("hold rsp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_data;
    check("hold data", held, 32'h0000_0038);
    req_valid = 1'b0;
    // hold for 5 cycles while the next request waits
    rs1_data = 32'h0000_0011; amount = 5'd1; req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("hold%0d data", c), rsp_data, 32'h0000_0038);
      check($sformatf("hold%0d valid", c), 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("handoff req_ready", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b0;
    #1;
    check("handoff idle", {30'd0, rsp_valid, busy}, 32'd0);
    check("handoff ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check("next accepted busy", 32'(busy), 32'd1);
    tick();
    check("next rsp_valid", 32'(rsp_valid), 32'd1);
    check("next data", rsp_data, 32'h0000_0022);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Flush in 2nd SHIFT cycle of a left shift by 16, then the same with reset
    for (int pass = 0; pass < 2; pass++) begin
      rs1_data = 32'h0000_0001; req_dir = 1'b0; req_arith = 1'b0; amount = 5'd16;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      check($sformatf("abort%0d in_shift", pass), 32'(busy), 32'd1);
      if (pass == 0) flush = 1'b1;
      else rst = 1'b1;
      tick();
      flush = 1'b0;
      rst = 1'b0;
      #1;
      check($sformatf("abort%0d busy", pass), 32'(busy), 32'd0);
      check($sformatf("abort%0d rsp_valid", pass), 32'(rsp_valid), 32'd0);
      check($sformatf("abort%0d req_ready", pass), 32'(req_ready), 32'd1);
      if (pass == 1) check("abort_rst rsp_data", rsp_data, 32'd0);
      else check("abort_flush rsp_data", rsp_data, 32'h0000_0010);
      saw_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
        tick();
        saw_valid |= rsp_valid;
      end
      check($sformatf("abort%0d never_valid", pass), 32'(saw_valid), 32'd0);
    end

    run_op(32'h0000_000F, 1'b1, 1'b0, 5'd2, 32'h0000_0003, 2, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
